sseg_mux_core: RTL and testbench

SSEG_MUX_CORE -- requirements
Module: sseg_mux_core

---
 rtl/sseg_pkg.sv | 43 ++++
 rtl/hex_to_sseg.sv | 11 +
 rtl/sseg_mux_core.sv | 171 +++++++++++++++++
 tb/tb_sseg_mux_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// CTRL field positions and the hex glyph table.
package sseg_pkg;

  typedef enum logic [4:0] {
    REG_CTRL     = 5'd0,
    REG_HEX      = 5'd1,
    REG_DP       = 5'd2,
    REG_RAW0     = 5'd3,
    REG_RAW1     = 5'd4,
    REG_PRESCALE = 5'd5
  } reg_idx_e;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_BLANK_LSB = 8;
  localparam int PRESCALE_W     = 20;

  // Active-high glyphs, segment a on bit 0 through g on bit 6.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Nibble to seven-segment decoder, active-high segment outputs.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = hex_glyph(hex);

endmodule

// File: rtl/sseg_mux_core.sv
// Multiplexed seven-segment display driver with an MMIO register slot:
// scans N_DIGITS digits, each held for PRESCALE+1 clocks, outputs registered.
module sseg_mux_core
  import sseg_pkg::*;
#(
  parameter int N_DIGITS         = 8,
  parameter int DEFAULT_PRESCALE = 100000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cs,
  input  logic                write,
  input  logic                read,
  input  logic [4:0]          address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic [N_DIGITS-1:0] anode_assert,
  output logic [6:0]          segs,
  output logic                dp
);

  localparam logic [63:0] ONE64      = 64'd1;
  localparam int          RAW0_DIGS  = (N_DIGITS > 4) ? 4 : N_DIGITS;
  localparam logic [31:0] DIG_MASK   = 32'((ONE64 << N_DIGITS) - ONE64);
  localparam logic [31:0] HEX_MASK   = 32'((ONE64 << (4 * N_DIGITS)) - ONE64);
  localparam logic [31:0] RAW0_MASK  = 32'((ONE64 << (8 * RAW0_DIGS)) - ONE64);
  localparam logic [31:0] RAW1_MASK  = (N_DIGITS > 4) ?
                                       32'((ONE64 << (8 * (N_DIGITS - 4))) - ONE64) : 32'd0;
  localparam logic [31:0] CTRL_MASK  = (DIG_MASK << CTRL_BLANK_LSB) | 32'h3;
  localparam logic [PRESCALE_W-1:0] PRESCALE_RESET = PRESCALE_W'(DEFAULT_PRESCALE);
  localparam logic [2:0]  LAST_IDX   = 3'(N_DIGITS - 1);

  logic [31:0]           ctrl_q, ctrl_d;
  logic [31:0]           hex_q, hex_d;
  logic [31:0]           dp_bits_q, dp_bits_d;
  logic [31:0]           raw0_q, raw0_d;
  logic [31:0]           raw1_q, raw1_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            segs_q, segs_d;
  logic                  dp_q, dp_d;

  logic        we;
  logic        prescale_wr;
  logic        enable;
  logic        hex_mode_raw;
  logic [3:0]  nibble;
  logic [63:0] raw_all;
  logic [6:0]  raw_seg;
  logic [6:0]  dec_seg;
  logic [6:0]  glyph;
  logic [7:0]  blank_mask;
  logic [31:0] rd_val;

  assign we           = cs & write;
  assign prescale_wr  = we && (address == REG_PRESCALE);
  assign enable       = ctrl_q[CTRL_EN_BIT];
  assign hex_mode_raw = ctrl_q[CTRL_MODE_BIT];

  always_comb begin
    ctrl_d     = ctrl_q;
    hex_d      = hex_q;
    dp_bits_d  = dp_bits_q;
    raw0_d     = raw0_q;
    raw1_d     = raw1_q;
    prescale_d = prescale_q;
    if (we) begin
      case (address)
        REG_CTRL:     ctrl_d     = write_data & CTRL_MASK;
        REG_HEX:      hex_d      = write_data & HEX_MASK;
        REG_DP:       dp_bits_d  = write_data & DIG_MASK;
        REG_RAW0:     raw0_d     = write_data & RAW0_MASK;
        REG_RAW1:     raw1_d     = write_data & RAW1_MASK;
        REG_PRESCALE: prescale_d = write_data[PRESCALE_W-1:0];
        default:      ;
      endcase
    end
  end

  // A PRESCALE write restarts the current slot rather than ending it.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (prescale_wr) begin
      cnt_d = '0;
    end else if (cnt_q >= prescale_q) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign nibble     = hex_q[{idx_q, 2'b00} +: 4];
  assign raw_all    = {raw1_q, raw0_q};
  assign raw_seg    = raw_all[{idx_q, 3'b000} +: 7];
  assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 8];

  hex_to_sseg u_dec (
    .hex  (nibble),
    .segs (dec_seg)
  );

  assign glyph = hex_mode_raw ? raw_seg : dec_seg;

  always_comb begin
    an_d   = '1;
    segs_d = 7'h7F;
    dp_d   = 1'b1;
    if (enable && !blank_mask[idx_q]) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        an_d[i] = (idx_q != 3'(i));
      end
      segs_d = ~glyph;
      dp_d   = ~dp_bits_q[idx_q];
    end
  end

  // Zero when the slot is not being read so the bus can OR slot outputs.
  always_comb begin
    rd_val = 32'd0;
    case (address)
      REG_CTRL:     rd_val = ctrl_q;
      REG_HEX:      rd_val = hex_q;
      REG_DP:       rd_val = dp_bits_q;
      REG_RAW0:     rd_val = raw0_q;
      REG_RAW1:     rd_val = raw1_q;
      REG_PRESCALE: rd_val = {{(32 - PRESCALE_W){1'b0}}, prescale_q};
      default:      rd_val = 32'd0;
    endcase
    read_data = (cs && read) ? rd_val : 32'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q     <= 32'h1;
      hex_q      <= '0;
      dp_bits_q  <= '0;
      raw0_q     <= '0;
      raw1_q     <= '0;
      prescale_q <= PRESCALE_RESET;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      segs_q     <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      hex_q      <= hex_d;
      dp_bits_q  <= dp_bits_d;
      raw0_q     <= raw0_d;
      raw1_q     <= raw1_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      segs_q     <= segs_d;
      dp_q       <= dp_d;
    end
  end

  assign anode_assert = an_q;
  assign segs         = segs_q;
  assign dp           = dp_q;

endmodule

// File: tb/tb_sseg_mux_core.sv
// Scoreboard bench for sseg_mux_core: stimulus queues expected display and
// read values tagged with a cycle number; the monitor checks them on negedges.
module tb_sseg_mux_core;

  localparam int DEF_P = 100000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, write, read;
  logic [4:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  anode_assert;
  logic [6:0]  segs;
  logic        dp;

  sseg_mux_core #(.N_DIGITS(8), .DEFAULT_PRESCALE(DEF_P)) dut (
    .clock        (clock),
    .reset        (reset),
    .cs           (cs),
    .write        (write),
    .read         (read),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .anode_assert (anode_assert),
    .segs         (segs),
    .dp           (dp)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [7:0]  an;
    logic [6:0]  sg;
    logic        dp;
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_timeouts = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic push_disp(input int c, input int digit, input bit blank,
                           input logic [6:0] g, input bit dp_lit, input string name);
    exp_t e;
    e.cyc = c; e.is_rd = 1'b0; e.rd = '0; e.name = name;
    if (blank) begin
      e.an = 8'hFF; e.sg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~(8'd1 << digit); e.sg = ~g; e.dp = ~dp_lit;
    end
    sb.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = c; e.is_rd = 1'b1; e.rd = v; e.name = name;
    e.an = '0; e.sg = '0; e.dp = 1'b0;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        n_checks++;
        if (sb[i].is_rd) begin
          if (read_data === sb[i].rd) n_pass++;
          else $display("FAIL %s cyc=%0d read_data=%h required %h",
                        sb[i].name, cyc, read_data, sb[i].rd);
        end else begin
          if (anode_assert === sb[i].an && segs === sb[i].sg && dp === sb[i].dp) n_pass++;
          else $display("FAIL %s cyc=%0d an/segs/dp=%h/%h/%b required %h/%h/%b",
                        sb[i].name, cyc, anode_assert, segs, dp,
                        sb[i].an, sb[i].sg, sb[i].dp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        $display("FAIL %s sampled at cyc=%0d required cyc %0d", sb[i].name, cyc, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; address = a; write_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic wr_rd(input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] old, input string name);
    cs = 1'b1; write = 1'b1; read = 1'b1; address = a; write_data = d;
    push_rd(cyc, old, name);
    tick();
    cs = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string name);
    cs = 1'b1; read = 1'b1; address = a;
    push_rd(cyc, v, name);
    tick();
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain pending=%0d required 0", sb.size());
      n_timeouts++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d;
    reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; write_data = '0;

    // reset values on outputs and registers
    for (int k = 1; k <= 3; k++) push_disp(k, 0, 1'b1, 7'h00, 1'b0, "reset_blank");
    repeat (3) tick();
    reset = 1'b0;
    push_disp(cyc + 1, 0, 1'b0, glyph(0), 1'b0, "post_reset_d0");
    rd(5'd0, 32'h1, "rst_ctrl");
    rd(5'd5, DEF_P, "rst_prescale");
    rd(5'd1, 32'h0, "rst_hex");
    rd(5'd7, 32'h0, "rst_unmapped");
    drain();

    // hex scan, PRESCALE=3
    wr(5'd0, 32'h0);
    wr(5'd1, 32'h7654_3210);
    wr(5'd5, 32'd3);
    wr(5'd0, 32'h1);
    e = cyc;
    for (int k = 1; k <= 36; k++) begin
      d = ((k - 1) / 4) % 8;
      push_disp(e + k, d, 1'b0, glyph(d), 1'b0, "hex_scan");
    end
    repeat (36) tick();
    drain();

    // blank digit 2
    wr(5'd0, 32'h0);
    wr(5'd0, 32'h401);
    e = cyc;
    for (int k = 1; k <= 32; k++) begin
      d = ((k - 1) / 4) % 8;
      push_disp(e + k, d, d == 2, glyph(d), 1'b0, "blank_d2");
    end
    rd(5'd0, 32'h401, "ctrl_readback");
    repeat (31) tick();
    drain();

    // raw mode with DP on digit 0
    wr(5'd0, 32'h0);
    wr(5'd3, 32'h0000_007F);
    wr(5'd2, 32'h1);
    wr(5'd0, 32'h3);
    e = cyc;
    for (int k = 1; k <= 32; k++) begin
      d = ((k - 1) / 4) % 8;
      push_disp(e + k, d, 1'b0, (d == 0) ? 7'h7F : 7'h00, d == 0, "raw_mode");
    end
    repeat (32) tick();
    drain();
    wr(5'd2, 32'h0);

    // PRESCALE=0 written on the terminal-count cycle of digit 0
    wr(5'd0, 32'h0);
    wr(5'd0, 32'h1);
    e = cyc;
    for (int k = 1; k <= 5; k++) push_disp(e + k, 0, 1'b0, glyph(0), 1'b0, "tc_hold");
    for (int k = 6; k <= 20; k++) begin
      d = (k - 5) % 8;
      push_disp(e + k, d, 1'b0, glyph(d), 1'b0, "fast_scan");
    end
    repeat (3) tick();
    wr_rd(5'd5, 32'd0, 32'd3, "rd_during_wr");
    rd(5'd5, 32'd0, "prescale_new");
    repeat (15) tick();
    drain();

    // disable mid-scan then re-enable
    wr(5'd5, 32'd3);
    wr(5'd0, 32'h0);
    wr(5'd0, 32'h1);
    e = cyc;
    for (int k = 1; k <= 7; k++) push_disp(e + k, (k - 1) / 4, 1'b0, glyph((k - 1) / 4), 1'b0, "pre_disable");
    for (int k = 8; k <= 11; k++) push_disp(e + k, 0, 1'b1, 7'h00, 1'b0, "disabled");
    for (int k = 12; k <= 15; k++) push_disp(e + k, 0, 1'b0, glyph(0), 1'b0, "reenable_d0");
    push_disp(e + 16, 1, 1'b0, glyph(1), 1'b0, "reenable_d1");
    repeat (6) tick();
    wr(5'd0, 32'h0);
    repeat (3) tick();
    wr(5'd0, 32'h1);
    repeat (5) tick();
    drain();

    // reset mid-scan with PRESCALE=5
    wr(5'd0, 32'h0);
    wr(5'd5, 32'd5);
    wr(5'd0, 32'h1);
    e = cyc;
    for (int k = 1; k <= 7; k++) push_disp(e + k, (k - 1) / 6, 1'b0, glyph((k - 1) / 6), 1'b0, "p5_scan");
    repeat (8) tick();
    reset = 1'b1;
    for (int k = 8; k <= 10; k++) push_disp(e + k, 0, 1'b1, 7'h00, 1'b0, "midscan_reset");
    repeat (2) tick();
    reset = 1'b0;
    push_disp(cyc + 1, 0, 1'b0, glyph(0), 1'b0, "after_reset_d0");
    rd(5'd5, DEF_P, "prescale_default");
    rd(5'd7, 32'h0, "addr7_zero");
    rd(5'd0, 32'h1, "ctrl_default");
    cs = 1'b0; write = 1'b1; address = 5'd1; write_data = 32'hDEAD_BEEF;
    tick();
    write = 1'b0;
    rd(5'd1, 32'h0, "cs_low_ignored");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks + n_timeouts);
    $finish;
  end

endmodule
